fl1p3_bank_arb: RTL and testbench

Two-requester arbiter and load sequencer for a WIDTH-bit bank of preset-able, mux-load, clock-enabled register slices. Two independent writers share the bank through a req/grant handshake. The block picks a winner, drives the bank's data-select (SD) and clock-enable (SP) for exactly one load cycle, then acknowledges. It sits between bus-side writers and the mux-load register bank and owns every SD/SP decision for that bank.

---
 rtl/fl1p3_bank_arb_if.sv | 35 +++
 rtl/fl1p3_bank_arb.sv | 113 +++++++++++
 tb/tb_fl1p3_bank_arb.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fl1p3_bank_arb_if.sv
// fl1p3_bank_arb_if
// Bundles the writer-side request/data/grant signals and the bank-side
// control/data signals of the two-requester bank arbiter.
//   REQ0/REQ1  : level load requests, held until the matching grant
//   D0/D1      : requester data, stable while the request is high
//   GNT0/GNT1  : one-cycle acknowledge, Q now holds the granted data
//   SD         : bank data select (0 -> D0, 1 -> D1)
//   SP         : bank load enable, high only during the load cycle
//   Q          : bank contents
//   BUSY       : arbiter is not idle
// Modports: slave = arbiter side, master = requester/bench side.
interface fl1p3_bank_arb_if #(
  parameter int WIDTH = 8
);
  logic             REQ0;
  logic             REQ1;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic             GNT0;
  logic             GNT1;
  logic             SD;
  logic             SP;
  logic [WIDTH-1:0] Q;
  logic             BUSY;

  modport slave (
    input  REQ0, REQ1, D0, D1,
    output GNT0, GNT1, SD, SP, Q, BUSY
  );

  modport master (
    output REQ0, REQ1, D0, D1,
    input  GNT0, GNT1, SD, SP, Q, BUSY
  );
endinterface

// File: rtl/fl1p3_bank_arb.sv
// fl1p3_bank_arb
// Arbiter and load sequencer for a WIDTH-bit preset-able, mux-load register
// bank shared by two writers. A winner is latched in IDLE, the bank is loaded
// in LOAD (SP=1, SD=SEL), and the winner is acknowledged in ACK.
// Ports:
//   CK    : rising-edge clock
//   RSTN  : asynchronous active-low reset (bank presets to all ones)
//   bus   : fl1p3_bank_arb_if.slave (REQ0/1, D0/1 in; GNT0/1, SD, SP, Q, BUSY out)
// Configuration macro:
//   FL1P3_ARB_FIXED_PRI_EN : defined -> requester 0 wins every tie and the
//                            round-robin pointer is removed; undefined ->
//                            round-robin arbitration.
module fl1p3_bank_arb #(
  parameter int WIDTH = 8
) (
  input  logic                    CK,
  input  logic                    RSTN,
  fl1p3_bank_arb_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  logic             sel;
  logic             sp_r;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             busy_r;
  logic [WIDTH-1:0] q_r;
  logic             winner;

`ifdef FL1P3_ARB_FIXED_PRI_EN
  // Requester 0 wins whenever it asks; otherwise only requester 1 can be up.
  always_comb begin
    winner = ~bus.REQ0;
  end
`else
  // pri points at the requester that lost the last grant.
  logic pri;

  always_comb begin
    winner = 1'b0;
    if (bus.REQ0 && bus.REQ1) begin
      winner = pri;
    end else begin
      winner = bus.REQ1;
    end
  end
`endif

  // Control outputs are registered alongside the state so none of them
  // has a combinational path from REQ.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      sel    <= 1'b0;
      sp_r   <= 1'b0;
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      busy_r <= 1'b0;
      q_r    <= '1;
`ifndef FL1P3_ARB_FIXED_PRI_EN
      pri    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ0 || bus.REQ1) begin
            state  <= LOAD;
            sel    <= winner;
            sp_r   <= 1'b1;
            busy_r <= 1'b1;
          end
        end
        LOAD: begin
          state  <= ACK;
          sp_r   <= 1'b0;
          q_r    <= sel ? bus.D1 : bus.D0;
          gnt0_r <= ~sel;
          gnt1_r <= sel;
        end
        ACK: begin
          state  <= IDLE;
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
          busy_r <= 1'b0;
`ifndef FL1P3_ARB_FIXED_PRI_EN
          pri    <= ~sel;
`endif
        end
        default: begin
          state  <= IDLE;
          sp_r   <= 1'b0;
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT0 = gnt0_r;
  assign bus.GNT1 = gnt1_r;
  assign bus.SD   = sel;
  assign bus.SP   = sp_r;
  assign bus.Q    = q_r;
  assign bus.BUSY = busy_r;

endmodule

// File: tb/tb_fl1p3_bank_arb.sv
// tb_fl1p3_bank_arb
// Directed bench for fl1p3_bank_arb. Stimulus pushes the expected grant
// (requester id and Q value) into a queue; a monitor on the falling edge pops
// and compares every time a grant is presented, and also watches the output
// invariants and the request-hold protocol.
module tb_fl1p3_bank_arb;

  logic ck;
  logic rstn;

  fl1p3_bank_arb_if #(.WIDTH(8)) bus ();

  fl1p3_bank_arb #(.WIDTH(8)) dut (
    .CK   (ck),
    .RSTN (rstn),
    .bus  (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct packed {
    logic       id;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on grant plus invariants every cycle.
  always @(negedge ck) begin
    exp_t e;
    chk("gnt_exclusive", {31'd0, bus.GNT0 & bus.GNT1}, 32'd0);
    chk("sp_implies_busy", {31'd0, bus.SP & ~bus.BUSY}, 32'd0);
    if (bus.SP) begin
      chk("req_held_in_load", {31'd0, bus.SD ? bus.REQ1 : bus.REQ0}, 32'd1);
    end
    if (bus.GNT0 || bus.GNT1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_gnt: got GNT0=%0b GNT1=%0b expected no grant at %0t",
                 bus.GNT0, bus.GNT1, $time);
      end else begin
        e = sb.pop_front();
        chk("gnt_id", {31'd0, bus.GNT1}, {31'd0, e.id});
        chk("q_at_gnt", {24'd0, bus.Q}, {24'd0, e.q});
        chk("sd_at_gnt", {31'd0, bus.SD}, {31'd0, e.id});
      end
    end
  end

  // Waits for a grant on the falling edge; n = falling edges consumed.
  task automatic wait_gnt(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ck);
      n++;
      if (bus.GNT0 || bus.GNT1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout: got no grant expected grant within 20 cycles at %0t", $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn     = 1'b0;
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    bus.D0   = 8'h00;
    bus.D1   = 8'h00;

    // Reset state
    repeat (2) @(negedge ck);
    chk("rst_q", {24'd0, bus.Q}, 32'hFF);
    chk("rst_sp", {31'd0, bus.SP}, 32'd0);
    chk("rst_gnt0", {31'd0, bus.GNT0}, 32'd0);
    chk("rst_gnt1", {31'd0, bus.GNT1}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_sd", {31'd0, bus.SD}, 32'd0);
    #1 rstn = 1'b1;

    // Single load from requester 0
    @(negedge ck);
    #1;
    bus.D0   = 8'h3C;
    bus.REQ0 = 1'b1;
    sb.push_back('{id: 1'b0, q: 8'h3C});
    @(negedge ck);
    chk("load_sp", {31'd0, bus.SP}, 32'd1);
    chk("load_sd", {31'd0, bus.SD}, 32'd0);
    chk("load_busy", {31'd0, bus.BUSY}, 32'd1);
    chk("load_q_unchanged", {24'd0, bus.Q}, 32'hFF);
    @(negedge ck);
    chk("ack_gnt0", {31'd0, bus.GNT0}, 32'd1);
    chk("ack_gnt1", {31'd0, bus.GNT1}, 32'd0);
    chk("ack_sp", {31'd0, bus.SP}, 32'd0);
    #1 bus.REQ0 = 1'b0;
    @(negedge ck);
    chk("post_gnt0", {31'd0, bus.GNT0}, 32'd0);
    chk("post_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("post_q", {24'd0, bus.Q}, 32'h3C);

    // Hold: no requests, data toggling
    for (int i = 0; i < 10; i++) begin
      #1;
      bus.D0 = 8'(i * 37 + 5);
      bus.D1 = 8'(~(i * 53));
      @(negedge ck);
      chk("hold_q", {24'd0, bus.Q}, 32'h3C);
      chk("hold_sp", {31'd0, bus.SP}, 32'd0);
      chk("hold_busy", {31'd0, bus.BUSY}, 32'd0);
    end

    // Tie arbitration from a fresh reset
    #1 rstn = 1'b0;
    @(negedge ck);
    chk("rst2_q", {24'd0, bus.Q}, 32'hFF);
    #1;
    rstn     = 1'b1;
    bus.D0   = 8'h11;
    bus.D1   = 8'h22;
    bus.REQ0 = 1'b1;
    bus.REQ1 = 1'b1;
`ifdef FL1P3_ARB_FIXED_PRI_EN
    for (int k = 0; k < 3; k++) sb.push_back('{id: 1'b0, q: 8'h11});
    sb.push_back('{id: 1'b1, q: 8'h22});
    for (int k = 0; k < 3; k++) begin
      wait_gnt(n);
      chk("tie_spacing", n, (k == 0) ? 32'd2 : 32'd3);
    end
    #1 bus.REQ0 = 1'b0;
    wait_gnt(n);
    chk("tie_spacing_req1", n, 32'd3);
    #1 bus.REQ1 = 1'b0;
`else
    sb.push_back('{id: 1'b0, q: 8'h11});
    sb.push_back('{id: 1'b1, q: 8'h22});
    sb.push_back('{id: 1'b0, q: 8'h11});
    sb.push_back('{id: 1'b1, q: 8'h22});
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n);
      chk("tie_spacing", n, (k == 0) ? 32'd2 : 32'd3);
    end
    #1;
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
`endif
    repeat (3) @(negedge ck);
    chk("tie_idle_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("tie_final_q", {24'd0, bus.Q}, 32'h22);

    // Reset asserted during LOAD
    #1;
    bus.D1   = 8'hA5;
    bus.REQ1 = 1'b1;
    @(negedge ck);
    chk("mid_load_sp", {31'd0, bus.SP}, 32'd1);
    chk("mid_load_sd", {31'd0, bus.SD}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_q", {24'd0, bus.Q}, 32'hFF);
    chk("mid_rst_sp", {31'd0, bus.SP}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("mid_rst_gnt1", {31'd0, bus.GNT1}, 32'd0);
    chk("mid_rst_sd", {31'd0, bus.SD}, 32'd0);
    repeat (2) @(negedge ck);
    chk("mid_rst_hold_q", {24'd0, bus.Q}, 32'hFF);
    #1 rstn = 1'b1;
    sb.push_back('{id: 1'b1, q: 8'hA5});
    wait_gnt(n);
    chk("rerun_spacing", n, 32'd2);
    #1 bus.REQ1 = 1'b0;
    repeat (3) @(negedge ck);
    chk("rerun_q", {24'd0, bus.Q}, 32'hA5);
    chk("rerun_busy", {31'd0, bus.BUSY}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
